// File: rtl/pipe_stage_buf_pkg.sv
// Shared constants for the inter-stage payload buffers: payload field layout,
// NOP encoding and occupancy/pointer width helpers.
package pipe_pkg;

    localparam int WORD_W       = 32;
    localparam int PC_W         = 32;
    localparam int INSTR_W      = 32;
    localparam int NUM_FIELDS   = 5;
    localparam int STAGE_DATA_W = NUM_FIELDS * WORD_W;

    // Field order inside the payload, LSB first: ext32, rt_data, ALUAns, Instr, PC
    localparam int EXT32_OFF   = 0;
    localparam int RT_DATA_OFF = 32;
    localparam int ALUANS_OFF  = 64;
    localparam int INSTR_OFF   = 96;
    localparam int PC_OFF      = 128;

    localparam logic [INSTR_W-1:0]      NOP_INSTR    = 32'h0000_0000;
    localparam logic [STAGE_DATA_W-1:0] STAGE_BUBBLE = STAGE_DATA_W'(NOP_INSTR) << INSTR_OFF;

    localparam int MAX_DEPTH = 8;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic [occ_w(MAX_DEPTH)-1:0] occ_t;

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready payload stream between pipeline stages.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 160
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_buf_mem.sv
// DEPTH x DATA_W storage for pipe_stage_buf: one write port, combinational read,
// no reset on the array.
module pipe_stage_mem #(
    parameter int DATA_W = 160,
    parameter int DEPTH  = 2,
    parameter int PTR_W  = 1
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [PTR_W-1:0]  wr_ptr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [PTR_W-1:0]  rd_ptr_i,
    output logic [DATA_W-1:0] rd_data_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_ptr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_ptr_i];
endmodule

// File: rtl/pipe_stage_buf.sv
// DEPTH-entry elastic pipeline register with valid/ready, sync flush and bubble output.
// Optional PIPE_STAGE_BUF_STATS_EN adds saturating stall/bubble cycle counters.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 160,
    parameter int                DEPTH      = 2,
    parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    pipe_stage_buf_if.slave          in_if,
    pipe_stage_buf_if.master         out_if,
    output logic [occ_w(DEPTH)-1:0]  occupancy_o
`ifdef PIPE_STAGE_BUF_STATS_EN
    ,
    output logic [31:0]              stall_cnt_o,
    output logic [31:0]              bubble_cnt_o
`endif
);
    localparam int               PTR_W    = ptr_w(DEPTH);
    localparam int               OCC_W    = occ_w(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam occ_t             FULL_OCC = occ_t'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    occ_t              occ_q, occ_d;
    logic              push, pop, out_valid;
    logic [DATA_W-1:0] rd_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign out_valid    = (occ_q != '0);
    assign pop          = out_valid & out_if.ready;
    // pop lets a full buffer take a new word in the same cycle it releases one
    assign in_if.ready  = (occ_q < FULL_OCC) | pop;
    assign push         = in_if.valid & in_if.ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = out_valid ? rd_data : BUBBLE_VAL;
    assign occupancy_o  = occ_q[OCC_W-1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    pipe_stage_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (push & ~flush_i),
        .wr_ptr_i  (wr_ptr_q),
        .wr_data_i (in_if.data),
        .rd_ptr_i  (rd_ptr_q),
        .rd_data_o (rd_data)
    );

`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0] stall_cnt_q, bubble_cnt_q;

    // Counters deliberately ignore flush so they span pipeline redirects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (out_valid && !out_if.ready && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (!out_valid && out_if.ready && !(&bubble_cnt_q))
                bubble_cnt_q <= bubble_cnt_q + 1'b1;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: DEPTH=2 directed vectors and DEPTH=3 random run
// against a queue-based reference model.
module tb_pipe_stage_buf;
    import pipe_pkg::*;

    localparam int W2 = 160;
    localparam int W3 = 32;
    localparam logic [W2-1:0] BUB2 = '0;
    localparam logic [W3-1:0] BUB3 = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic reset;
    logic fl2, fl3;
    always #5 clk = ~clk;

    pipe_stage_buf_if #(.DATA_W(W2)) in2 ();
    pipe_stage_buf_if #(.DATA_W(W2)) out2 ();
    pipe_stage_buf_if #(.DATA_W(W3)) in3 ();
    pipe_stage_buf_if #(.DATA_W(W3)) out3 ();

    logic [occ_w(2)-1:0] occ2;
    logic [occ_w(3)-1:0] occ3;
`ifdef PIPE_STAGE_BUF_STATS_EN
    logic [31:0] st2, bu2, st3, bu3;
`endif

    pipe_stage_buf #(.DATA_W(W2), .DEPTH(2), .BUBBLE_VAL(BUB2)) dut2 (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (fl2),
        .in_if       (in2),
        .out_if      (out2),
        .occupancy_o (occ2)
`ifdef PIPE_STAGE_BUF_STATS_EN
        ,
        .stall_cnt_o  (st2),
        .bubble_cnt_o (bu2)
`endif
    );

    pipe_stage_buf #(.DATA_W(W3), .DEPTH(3), .BUBBLE_VAL(BUB3)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .flush_i     (fl3),
        .in_if       (in3),
        .out_if      (out3),
        .occupancy_o (occ3)
`ifdef PIPE_STAGE_BUF_STATS_EN
        ,
        .stall_cnt_o  (st3),
        .bubble_cnt_o (bu3)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W2-1:0] act, input logic [W2-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [W2-1:0] pl(input logic [31:0] x);
        return {x, ~x, x ^ 32'h5A5A_5A5A, x + 32'd1, x};
    endfunction

    typedef struct {
        logic          iv;
        logic [W2-1:0] d;
        logic          ordy;
        logic          fl;
        logic          e_rdy;
        logic          e_vld;
        logic [W2-1:0] e_data;
        int            e_occ;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic iv, input logic [W2-1:0] d, input logic ordy, input logic fl,
                       input logic e_rdy, input logic e_vld, input logic [W2-1:0] e_data,
                       input int e_occ);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_occ = e_occ;
        tv.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dut2(input string tag, input logic rdy, input logic vld,
                            input logic [W2-1:0] data, input int occ);
        chk({tag, ".in_ready"}, in2.ready, rdy);
        chk({tag, ".out_valid"}, out2.valid, vld);
        chk({tag, ".out_data"}, out2.data, data);
        chk({tag, ".occupancy"}, occ2, occ);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] q[$];
        logic        iv, ordy, fl, e_rdy, e_vld;
        logic [31:0] d, e_data;

        reset = 1'b1;
        fl2 = 1'b0; fl3 = 1'b0;
        in2.valid = 1'b0; in2.data = '0; out2.ready = 1'b0;
        in3.valid = 1'b0; in3.data = '0; out3.ready = 1'b0;
        #1;
        chk_dut2("reset2", 1'b1, 1'b0, BUB2, 0);
        chk("reset3.out_data", out3.data, BUB3);
        chk("reset3.in_ready", in3.ready, 1'b1);
        tick();
        reset = 1'b0;

        // backpressure fill A,B, C refused, full push+pop, drain
        add(1, pl(32'hA), 0, 0, 1, 0, BUB2,      0);
        add(1, pl(32'hB), 0, 0, 1, 1, pl(32'hA), 1);
        add(1, pl(32'hC), 0, 0, 0, 1, pl(32'hA), 2);
        add(1, pl(32'hC), 1, 0, 1, 1, pl(32'hA), 2);
        add(0, '0,        1, 0, 1, 1, pl(32'hB), 2);
        add(0, '0,        1, 0, 1, 1, pl(32'hC), 1);
        add(0, '0,        1, 0, 1, 0, BUB2,      0);
        // flush with simultaneous push and pop
        add(1, pl(32'hD), 0, 0, 1, 0, BUB2,      0);
        add(1, pl(32'hE), 0, 0, 1, 1, pl(32'hD), 1);
        add(1, pl(32'hF), 1, 1, 1, 1, pl(32'hD), 2);
        add(0, '0,        1, 0, 1, 0, BUB2,      0);
        add(0, '0,        1, 0, 1, 0, BUB2,      0);
        // single word latency, then empty again
        add(1, pl(32'h1234), 1, 0, 1, 0, BUB2,         0);
        add(0, '0,           1, 0, 1, 1, pl(32'h1234), 1);
        add(0, '0,           1, 0, 1, 0, BUB2,         0);
        // in_data changes without in_valid are ignored
        add(0, pl(32'h9999), 0, 0, 1, 0, BUB2, 0);
        add(0, pl(32'h7777), 1, 0, 1, 0, BUB2, 0);
        add(0, '0,           1, 0, 1, 0, BUB2, 0);

        for (int i = 0; i < tv.size(); i++) begin
            in2.valid  = tv[i].iv;
            in2.data   = tv[i].d;
            out2.ready = tv[i].ordy;
            fl2        = tv[i].fl;
            #1;
            chk_dut2($sformatf("vec%0d", i), tv[i].e_rdy, tv[i].e_vld, tv[i].e_data, tv[i].e_occ);
            tick();
        end
        fl2 = 1'b0;

        // async reset mid-cycle with two entries stored
        in2.valid = 1'b1; in2.data = pl(32'h1); out2.ready = 1'b0;
        tick();
        in2.data = pl(32'h2);
        tick();
        in2.valid = 1'b0;
        #1;
        chk("arst.pre_occ", occ2, 2);
        #2;
        reset = 1'b1;
        #1;
        chk_dut2("arst.during", 1'b1, 1'b0, BUB2, 0);
        #1;
        reset = 1'b0;
        tick();
        chk_dut2("arst.after", 1'b1, 1'b0, BUB2, 0);
        in2.valid = 1'b1; in2.data = pl(32'h77); out2.ready = 1'b1;
        tick();
        in2.valid = 1'b0;
        #1;
        chk_dut2("arst.push", 1'b1, 1'b1, pl(32'h77), 1);
        tick();
        out2.ready = 1'b0;

        // DEPTH=3 random run against queue model
        for (int c = 0; c < 600; c++) begin
            iv   = ($urandom % 4) != 0;
            ordy = (c < 300) ? (($urandom % 3) == 0) : (($urandom % 3) != 0);
            fl   = ($urandom % 30) == 0;
            d    = $urandom;
            e_vld  = q.size() > 0;
            e_rdy  = (q.size() < 3) || (e_vld && ordy);
            e_data = e_vld ? q[0] : BUB3;
            in3.valid = iv; in3.data = d; out3.ready = ordy; fl3 = fl;
            #1;
            chk("rnd.in_ready", in3.ready, e_rdy);
            chk("rnd.out_valid", out3.valid, e_vld);
            chk("rnd.out_data", out3.data, e_data);
            chk("rnd.occupancy", occ3, q.size());
            chk("rnd.occ_le_depth", occ3 <= 3, 1'b1);
            if (fl) q.delete();
            else begin
                if (e_vld && ordy) void'(q.pop_front());
                if (iv && e_rdy)   q.push_back(d);
            end
            tick();
        end
        in3.valid = 1'b0; out3.ready = 1'b0; fl3 = 1'b0;

`ifdef PIPE_STAGE_BUF_STATS_EN
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
        in2.valid = 1'b1; in2.data = pl(32'h55); out2.ready = 1'b0;
        tick();
        in2.valid = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        fl2 = 1'b1;
        tick();
        fl2 = 1'b0;
        tick();
        chk("stats.stall", st2, 5);
        chk("stats.bubble0", bu2, 0);
        chk("stats.occ", occ2, 0);
        out2.ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        out2.ready = 1'b0;
        #1;
        chk("stats.bubble3", bu2, 3);
        chk("stats.stall_hold", st2, 5);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised successor of the fixed-field inter-stage pipeline registers (D/E, E/M, M/W).
- Carries one opaque payload vector (PC, Instr, ALU result, operands, flags, concatenated by the instantiating stage) through a DEPTH-entry elastic buffer.
- Uses valid/ready handshake, synchronous flush, and bubble (NOP) insertion when empty.
- Replaces ad-hoc WrEn stall logic with back-pressure. DEPTH=1 acts as a classic stage register; DEPTH=2 acts as a skid buffer.

Parameters:
- DATA_W, 160, payload width in bits (default = 5 x 32-bit fields).
- DEPTH, 2, number of storage entries; legal range 1..8, need not be a power of 2.
- BUBBLE_VAL, {DATA_W{1'b0}}, value driven on out_data when empty (all-zero = NOP instr, PC 0).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all stored entries
- in_valid  in  1  upstream stage presents in_data
- in_ready  out  1  buffer can accept this cycle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream consumes head this cycle
- out_data  out  DATA_W  head payload, or BUBBLE_VAL when empty
- occupancy  out  $clog2(DEPTH+1)  number of stored entries

Behaviour:
- Reset: asynchronous and active-high. All outputs go immediately to their reset values:
  - out_valid=0, out_data=BUBBLE_VAL, occupancy=0, in_ready=1.
  - Read/write pointers = 0.
  - Storage contents are don't-care.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- in_ready = (occupancy < DEPTH) | pop. Full-and-popping accepts a push in the same cycle. The pop term is the only combinational in->out path.
- out_valid = (occupancy != 0). It is derived from registered state only.
- out_data: head entry when out_valid=1, else BUBBLE_VAL. Never shows stale data after a pop empties the buffer.
- Latency: a push into an empty buffer appears on out_data/out_valid the next cycle. There is no same-cycle bypass.
- Ordering: strict FIFO.
- Pointers: increment modulo DEPTH; explicit wrap DEPTH-1 -> 0.
- Occupancy update:
  - push only: +1
  - pop only: -1
  - both: unchanged; head advances and tail writes.
  - push when full without pop: impossible, because in_ready=0.
- Flush (synchronous, highest priority):
  - On the edge, occupancy=0 and pointers=0.
  - Any simultaneous push is discarded and any simultaneous pop is ignored.
  - Next cycle: out_valid=0, out_data=BUBBLE_VAL.
  - in_ready is unaffected in the flush cycle.
- Reset asserted mid-operation: all state is lost immediately. After deassertion the block behaves as freshly reset.
- in_data is sampled only on push. Changes to in_data while in_valid=0 are ignored.
- in_valid/in_data are not required to be held stable while in_ready=0. The upstream stage retries.

Optional Feature:
- Macro PIPE_STAGE_BUF_STATS_EN.
- When defined:
  - Adds output stall_cnt [31:0]: saturating count of cycles with out_valid=1 & out_ready=0.
  - Adds output bubble_cnt [31:0]: saturating count of cycles with out_valid=0 & out_ready=1.
  - Both counters clear on reset, are unaffected by flush, and saturate at 32'hFFFF_FFFF.
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package pipe_pkg holds:
  - field width/offset constants for the stage payloads (PC_W=32, INSTR_W=32, and the offsets of PC, Instr, ALUAns, rt_data, ext32 within DATA_W);
  - the NOP instruction constant used to build BUBBLE_VAL;
  - typedef occ_t (occupancy width function).
- One sub-module, pipe_stage_mem: DEPTH x DATA_W register array with a write port (wr_en, wr_ptr, wr_data) and a combinational read (rd_ptr). It has no reset on storage.
- Pointer and occupancy control stays in pipe_stage_buf.

Test Plan:
- Reset, then push 32'h1234 with out_ready=1 → out_valid=1 and out_data=32'h1234 one cycle later; cycle after that → out_valid=0, out_data=BUBBLE_VAL.
- DEPTH=2, out_ready=0, push A, B, C on three consecutive cycles → A and B stored; in_ready=0 after B; occupancy=2; C not accepted. Then out_ready=1 → A, B, C emerge in order.
- DEPTH=3 wrap-around: 10 pushes and 10 pops interleaved with random out_ready → FIFO order preserved across pointer wrap 2→0; occupancy never exceeds 3.
- Full with push & pop in the same cycle → occupancy stays DEPTH, in_ready=1 that cycle, head advances, new entry lands at tail.
- Occupancy=2 with flush=1 and in_valid=1 in the same cycle → next cycle occupancy=0, out_valid=0, out_data=BUBBLE_VAL; pushed word is never output.
- Async reset pulsed mid-cycle with occupancy=2 → out_valid=0 and occupancy=0 immediately, before the next clock edge. With PIPE_STAGE_BUF_STATS_EN: hold out_ready=0 with data for 5 cycles → stall_cnt=5; a following flush leaves it at 5.
